f3_move_sched: RTL
==================

// Module: f3_move_sched
// PURPOSE
//  Sequences Function-3 keypad commands into single puzzle moves for the board engine.
//  - Detects each new command strobe from the keypad processor.
//  - Queues direction commands in a small FIFO.
//  - Expands Scramble into a burst of pseudo-random moves.
//  - Issues every move over a valid/ready handshake.
// PARAMETERS
//  FIFO_DEPTH      4        queued direction commands; power of two, >=2
//  SCRAMBLE_MOVES  32       moves issued per Scramble; 1..255
//  LFSR_SEED       16'hACE1 LFSR reset value; must be nonzero
// PORTS
//  sysclk       in   1  system clock; all logic on posedge
//  rst_n        in   1  asynchronous active-low reset
//  set          in   1  keypad command present (level, registered upstream)
//  instruction  in   4  0 none, 1 North, 2 East, 3 West, 4 South, 5 Scramble
//  move_valid   out  1  move_dir holds a move for the board engine
//  move_dir     out  2  move encoding: N=0, E=1, S=2, W=3
//  move_ready   in   1  board engine accepts the move at this posedge
//  busy         out  1  state!=IDLE, or FIFO non-empty, or scramble pending
//  scrambling   out  1  state==SCRAMBLE
//  cmd_drop     out  1  one-cycle pulse: a strobed command was discarded
// BEHAVIOUR
//  Reset values
//  - All outputs 0; FIFO empty; state IDLE; set_d=0; LFSR=LFSR_SEED; pending=0.
//  - Reset mid-handshake aborts the move; it is not reissued.
//  Strobe and command mapping
//  - stb = set & ~set_d. Only a rising edge of set counts; a held key is one command.
//  - Codes 1-4: push the mapped dir at the stb edge (1->0, 2->1, 3->3, 4->2).
//  - Code 5: sets scramble pending.
//  - Code 0 or 6-15 with stb: ignored, no drop pulse.
//  Drop rules (cmd_drop pulses the cycle after the stb edge)
//  - Direction stb while FIFO full.
//  - Direction stb while state==SCRAMBLE or pending=1.
//  - Scramble stb while already pending or SCRAMBLE.
//  Handshake
//  - Transfer occurs on posedge with move_valid & move_ready.
//  - move_dir is stable while move_valid=1 and not transferred.
//  - move_valid falls the cycle after a transfer unless a further move is ready.
//  - Back-to-back transfers of one move per cycle are supported.
//  Latency
//  - stb sampled at edge N with IDLE and FIFO empty -> move_valid=1 after edge N+1.
//  - A push and a pop in the same cycle are both honoured; a full FIFO still accepts the push.
//  States
//  - IDLE: if FIFO non-empty -> ISSUE; else if pending -> SCRAMBLE (clear pending, cnt=0, last=none).
//  - ISSUE: present FIFO head. On transfer, pop. FIFO empty after pop -> IDLE.
//  - SCRAMBLE: move_dir = cand; on transfer cnt++, last=move_dir; cnt==SCRAMBLE_MOVES -> IDLE.
//  - Pending scramble waits until the FIFO drains and the last user move transfers.
//  LFSR
//  - 16-bit Galois, mask 16'hB400, free-running every cycle.
//  - cand = lfsr[1:0], latched into move_dir when move_valid rises or after a transfer.
//  - Must not change while move_valid waits for move_ready.
// CONFIGURATION
//  F3_ANTIREVERSE_EN
//  - Defined: in SCRAMBLE, if cand == last^2 (opposite move), issue (cand+1)&3 instead.
//    No move ever undoes the immediately previous scramble move.
//  - Undefined: cand issued unmodified; reversals permitted.
//  - User moves are never altered in either build.
// STRUCTURE
//  - Shared package f3_pkg: instruction codes 0-5, DIR_N/E/S/W, state enum {IDLE,ISSUE,SCRAMBLE}.
//  - Sub-module f3_lfsr16 (sysclk, rst_n, SEED param, 16-bit state out).
//  - FIFO and FSM inline.
// TESTING
//  - Reset, then pulse set=1 with instr=2 for 3 cycles, move_ready=1.
//    -> exactly one move, dir=1, move_valid high 1 cycle, then busy=0.
//  - 5 stb of instr=1 with move_ready=0 (FIFO_DEPTH=4).
//    -> 4 queued, cmd_drop on 5th; then move_ready=1 -> four dir=0 on 4 consecutive cycles.
//  - instr=5 stb, move_ready=1 always.
//    -> scrambling high exactly 32 transfers; with F3_ANTIREVERSE_EN no adjacent pair XORs to 2.
//  - Queue N,E, then stb Scramble.
//    -> dirs 0,1 issued first, then scrambling=1; a dir stb during scramble -> cmd_drop, no extra move.
//  - move_valid=1, move_ready low 10 cycles.
//    -> move_dir constant across all 10 cycles.
//  - Assert rst_n=0 mid-scramble.
//    -> all outputs 0 asynchronously; after release, idle until next stb.

Source files
------------

// File: rtl/f3_pkg.sv
// Shared definitions for the Function-3 move scheduler: keypad instruction codes,
// move encodings and the scheduler state type.
package f3_pkg;

  localparam logic [3:0] INSTR_NONE     = 4'd0;
  localparam logic [3:0] INSTR_NORTH    = 4'd1;
  localparam logic [3:0] INSTR_EAST     = 4'd2;
  localparam logic [3:0] INSTR_WEST     = 4'd3;
  localparam logic [3:0] INSTR_SOUTH    = 4'd4;
  localparam logic [3:0] INSTR_SCRAMBLE = 4'd5;

  localparam logic [1:0] DIR_N = 2'd0;
  localparam logic [1:0] DIR_E = 2'd1;
  localparam logic [1:0] DIR_S = 2'd2;
  localparam logic [1:0] DIR_W = 2'd3;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ISSUE    = 2'd1,
    SCRAMBLE = 2'd2
  } state_t;

  // Keypad codes order West before South, the move encoding does not.
  function automatic logic [1:0] instr_to_dir(input logic [3:0] instr);
    case (instr)
      INSTR_EAST:  return DIR_E;
      INSTR_WEST:  return DIR_W;
      INSTR_SOUTH: return DIR_S;
      default:     return DIR_N;
    endcase
  endfunction

endpackage

// File: rtl/f3_lfsr16.sv
// Free-running 16-bit Galois LFSR (mask 16'hB400) used as the scramble move source.
module f3_lfsr16 #(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        sysclk,
  input  logic        rst_n,
  output logic [15:0] state
);

  localparam logic [15:0] MASK = 16'hB400;

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) state <= SEED;
    else        state <= state[0] ? ((state >> 1) ^ MASK) : (state >> 1);
  end

endmodule

// File: rtl/f3_move_sched.sv
// Function-3 move scheduler: keypad strobes -> direction FIFO / scramble burst -> valid/ready moves.
// Build option: define F3_ANTIREVERSE_EN to stop a scramble move from undoing the previous one.
module f3_move_sched
  import f3_pkg::*;
#(
  parameter int          FIFO_DEPTH     = 4,
  parameter int          SCRAMBLE_MOVES = 32,
  parameter logic [15:0] LFSR_SEED      = 16'hACE1
) (
  input  logic       sysclk,
  input  logic       rst_n,
  input  logic       set,
  input  logic [3:0] instruction,
  output logic       move_valid,
  output logic [1:0] move_dir,
  input  logic       move_ready,
  output logic       busy,
  output logic       scrambling,
  output logic       cmd_drop
);

  localparam int             PTR_W    = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W:0] CNT_FULL = (PTR_W + 1)'(FIFO_DEPTH);
  localparam logic [PTR_W:0] CNT_ONE  = (PTR_W + 1)'(1);
  localparam logic [7:0]     CNT_LAST = 8'(SCRAMBLE_MOVES - 1);

  state_t           state, state_nxt;
  logic             set_d;
  logic             pending, pending_nxt, pend_clr;
  logic [1:0]       fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] rd_ptr, wr_ptr, rd_ptr_inc;
  logic [PTR_W:0]   fifo_cnt;
  logic [7:0]       scr_cnt, scr_cnt_nxt;
  logic             valid_nxt, drop_nxt;
  logic [1:0]       dir_nxt, push_dir, head_next, cand, scr_follow;
  logic             stb, is_dir, is_scr, blocked, full, xfer, push, pop;
  logic [15:0]      lfsr_state;
  logic             unused_lfsr;

  f3_lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
    .sysclk (sysclk),
    .rst_n  (rst_n),
    .state  (lfsr_state)
  );

  assign cand        = lfsr_state[1:0];
  assign unused_lfsr = ^lfsr_state[15:2];

`ifdef F3_ANTIREVERSE_EN
  // XOR with 2 maps every move onto its opposite (N<->S, E<->W).
  assign scr_follow = (cand == (move_dir ^ 2'd2)) ? cand + 2'd1 : cand;
`else
  assign scr_follow = cand;
`endif

  assign stb        = set & ~set_d;
  assign is_dir     = (instruction >= INSTR_NORTH) && (instruction <= INSTR_SOUTH);
  assign is_scr     = (instruction == INSTR_SCRAMBLE);
  assign blocked    = (state == SCRAMBLE) || pending;
  assign full       = (fifo_cnt == CNT_FULL);
  assign xfer       = move_valid & move_ready;
  assign pop        = (state == ISSUE) && xfer;
  assign push_dir   = instr_to_dir(instruction);
  assign push       = stb && is_dir && !blocked && (!full || pop);
  assign drop_nxt   = stb && ((is_dir && (blocked || (full && !pop))) || (is_scr && blocked));
  assign rd_ptr_inc = rd_ptr + 1'b1;
  // With one entry left, the next head is whatever is being pushed this same cycle.
  assign head_next  = (fifo_cnt == CNT_ONE) ? push_dir : fifo_mem[rd_ptr_inc];

  assign pending_nxt = (pending && !pend_clr) || (stb && is_scr && !blocked);
  assign busy        = (state != IDLE) || (fifo_cnt != '0) || pending;
  assign scrambling  = (state == SCRAMBLE);

  always_comb begin
    state_nxt   = state;
    valid_nxt   = move_valid;
    dir_nxt     = move_dir;
    scr_cnt_nxt = scr_cnt;
    pend_clr    = 1'b0;
    case (state)
      IDLE: begin
        if (fifo_cnt != '0) begin
          state_nxt = ISSUE;
          valid_nxt = 1'b1;
          dir_nxt   = fifo_mem[rd_ptr];
        end else if (pending) begin
          state_nxt   = SCRAMBLE;
          pend_clr    = 1'b1;
          scr_cnt_nxt = '0;
          valid_nxt   = 1'b1;
          dir_nxt     = cand;
        end
      end
      ISSUE: begin
        if (xfer) begin
          if ((fifo_cnt != CNT_ONE) || push) begin
            dir_nxt = head_next;
          end else begin
            state_nxt = IDLE;
            valid_nxt = 1'b0;
          end
        end
      end
      SCRAMBLE: begin
        if (xfer) begin
          scr_cnt_nxt = scr_cnt + 8'd1;
          if (scr_cnt == CNT_LAST) begin
            state_nxt = IDLE;
            valid_nxt = 1'b0;
          end else begin
            dir_nxt = scr_follow;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
        valid_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      set_d      <= 1'b0;
      pending    <= 1'b0;
      scr_cnt    <= '0;
      move_valid <= 1'b0;
      move_dir   <= DIR_N;
      cmd_drop   <= 1'b0;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      fifo_cnt   <= '0;
    end else begin
      state      <= state_nxt;
      set_d      <= set;
      pending    <= pending_nxt;
      scr_cnt    <= scr_cnt_nxt;
      move_valid <= valid_nxt;
      move_dir   <= dir_nxt;
      cmd_drop   <= drop_nxt;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr_inc;
      if (push && !pop)      fifo_cnt <= fifo_cnt + 1'b1;
      else if (pop && !push) fifo_cnt <= fifo_cnt - 1'b1;
    end
  end

  // FIFO storage carries no reset; occupancy is tracked by the pointers above.
  always_ff @(posedge sysclk) begin
    if (push) fifo_mem[wr_ptr] <= push_dir;
  end

endmodule
